bot_feeder: RTL

Upstream producer for the 6-permutation input module: accepts a batch of bots (128-bit bot, 6-bit valid-permutation mask, extra data) from a source stream and writes them into the input module's bot FIFO. It throttles on the FIFO fill level it reports back, drops all-zero-mask bots, and signals batch completion. It sits between the bot-memory reader and the pipeline's input module, driving that module's write side.

---
 rtl/bot_feeder.sv | 119 +++++++++++
 1 files changed

// File: rtl/bot_feeder.sv
// Feeds a batch of bots into the input module's bot FIFO, dropping zero-mask bots. One-cycle latency from handshake to write strobe.
// srcReady is withheld while the projected FIFO fill would exceed ALMOST_FULL_THRESHOLD. Optional counters: BOT_FEEDER_STATS_EN.
module bot_feeder #(
  parameter int EXTRA_DATA_WIDTH      = 12,
  parameter int FIFO_DEPTH_LOG2       = 5,
  parameter int ALMOST_FULL_THRESHOLD = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 batchSize,
  output logic                        busy,
  output logic                        done,
  input  logic [127:0]                srcBot,
  input  logic [5:0]                  srcValidPermutes,
  input  logic [EXTRA_DATA_WIDTH-1:0] srcExtraData,
  input  logic                        srcValid,
  output logic                        srcReady,
  output logic [127:0]                bot,
  output logic                        anyBotPermutIsValid,
  output logic [5:0]                  validBotPermutesIn,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
  input  logic [FIFO_DEPTH_LOG2-1:0]  fifoFullness,
  output logic [15:0]                 droppedCount,
  output logic [15:0]                 emittedCount
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [FIFO_DEPTH_LOG2:0] THRESHOLD = (FIFO_DEPTH_LOG2+1)'(ALMOST_FULL_THRESHOLD);

  state_t                   state, state_nxt;
  logic [15:0]              remaining, remaining_nxt;
  logic [FIFO_DEPTH_LOG2:0] fill_proj;
  logic                     credit;
  logic                     handshake;
  logic                     keep;

  // One extra bit so a nearly full FIFO plus the pending write cannot wrap to a small value.
  assign fill_proj = {1'b0, fifoFullness}
                   + (FIFO_DEPTH_LOG2+1)'(anyBotPermutIsValid)
                   + (FIFO_DEPTH_LOG2+1)'(1);
  assign credit    = (fill_proj <= THRESHOLD);
  assign srcReady  = (state == RUN) && credit && (remaining != 16'd0);
  assign handshake = srcValid && srcReady;
  assign keep      = (srcValidPermutes != 6'd0);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    case (state)
      IDLE: begin
        if (start) begin
          remaining_nxt = batchSize;
          state_nxt     = (batchSize != 16'd0) ? RUN : FLUSH;
        end
      end
      RUN: begin
        if (handshake) begin
          remaining_nxt = remaining - 16'd1;
          if (remaining == 16'd1) state_nxt = FLUSH;
        end
      end
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= 16'd0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Strobe lasts exactly one cycle per kept bot; data holds between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      anyBotPermutIsValid <= 1'b0;
      bot                 <= '0;
      validBotPermutesIn  <= '0;
      extraDataIn         <= '0;
    end else begin
      anyBotPermutIsValid <= handshake && keep;
      if (handshake && keep) begin
        bot                <= srcBot;
        validBotPermutesIn <= srcValidPermutes;
        extraDataIn        <= srcExtraData;
      end
    end
  end

`ifdef BOT_FEEDER_STATS_EN
  logic [15:0] dropped_q, emitted_q;

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      dropped_q <= 16'd0;
      emitted_q <= 16'd0;
    end else begin
      if (handshake && !keep && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
      if (anyBotPermutIsValid && emitted_q != 16'hFFFF) emitted_q <= emitted_q + 16'd1;
    end
  end

  assign droppedCount = dropped_q;
  assign emittedCount = emitted_q;
`else
  assign droppedCount = 16'd0;
  assign emittedCount = 16'd0;
`endif

endmodule
